// File: rtl/noc_word_injector_if.sv
`default_nettype none
// ============================================================================
//  noc_word_injector_if
//  Load/replay/status bundle between the NoC word injector and its host.
//  Rev 1.0
// ============================================================================
interface noc_word_injector_if #(
    parameter int BIT_WIDTH = 4,
    parameter int LOG_N_ADD = 3,
    parameter int CTRL_BIT  = 1,
    parameter int LOG_N_CH  = 4,
    parameter int LOG_DEPTH = 2
);
    localparam int N_CH = 2 ** LOG_N_CH;
    localparam int W    = CTRL_BIT + LOG_N_ADD + BIT_WIDTH;
    localparam int CW   = LOG_DEPTH + 1;

    logic [N_CH-1:0]    ld;
    logic [N_CH*W-1:0]  data_in;
    logic               start;
    logic               mode;
    logic               stop;
    logic               clear;
    logic [N_CH-1:0]    stall;
    logic [N_CH*W-1:0]  out;
    logic [N_CH*CW-1:0] fill;
    logic               busy;
    logic               done;

    modport master (
        output ld, data_in, start, mode, stop, clear, stall,
        input  out, fill, busy, done
    );

    modport slave (
        input  ld, data_in, start, mode, stop, clear, stall,
        output out, fill, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/noc_word_injector.sv
`default_nettype none
// ============================================================================
//  noc_word_injector
//  Per-channel word buffers, loaded by strobes and replayed into the NoC.
//  Rev 1.0
// ============================================================================
module noc_word_injector #(
    parameter int BIT_WIDTH = 4,
    parameter int LOG_N_ADD = 3,
    parameter int CTRL_BIT  = 1,
    parameter int LOG_N_CH  = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    noc_word_injector_if.slave bus
);
    localparam int N_CH  = 2 ** LOG_N_CH;
    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam int W     = CTRL_BIT + LOG_N_ADD + BIT_WIDTH;
    localparam int CW    = LOG_DEPTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [N_CH-1:0] run_vec;
    logic [N_CH-1:0] done_vec;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            state_t               state;
            state_t               state_nx;
            logic [W-1:0]         mem [DEPTH];
            logic [LOG_DEPTH-1:0] wr_ptr;
            logic [LOG_DEPTH-1:0] rd_ptr;
            logic [CW-1:0]        cnt;
            logic [CW-1:0]        sent;
            logic                 mode_q;
            logic [W-1:0]         word;
            logic                 do_load;
            logic                 do_start;
            logic                 do_clear;
            logic                 consume;
            logic                 last_word;
            logic                 last_ptr;

            assign word      = mem[rd_ptr];
            assign last_word = (sent == cnt - CW'(1));
            assign last_ptr  = (CW'(rd_ptr) == cnt - CW'(1));

            always_comb begin
                state_nx = state;
                do_load  = 1'b0;
                do_start = 1'b0;
                do_clear = 1'b0;
                consume  = 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            do_start = 1'b1;
                            state_nx = (cnt != '0) ? ST_RUN : ST_DONE;
                        end else if (bus.ld[i] && (cnt < CW'(DEPTH))) begin
                            do_load = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Bubbles (V=0) drain even under backpressure.
                        consume = !word[W-1] || !bus.stall[i];
                        if (bus.stop || (consume && last_word && !mode_q)) begin
                            state_nx = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (bus.clear) begin
                            do_clear = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end
                    default: state_nx = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state <= ST_IDLE;
                end else begin
                    state <= state_nx;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    sent   <= '0;
                    mode_q <= 1'b0;
                end else begin
                    if (do_load) begin
                        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
                        cnt    <= cnt + CW'(1);
                    end
                    if (do_start) begin
                        mode_q <= bus.mode;
                        rd_ptr <= '0;
                        sent   <= '0;
                    end
                    if (consume) begin
                        rd_ptr <= last_ptr ? '0 : rd_ptr + LOG_DEPTH'(1);
                        sent   <= last_word ? '0 : sent + CW'(1);
                    end
                    if (do_clear) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        cnt    <= '0;
                        sent   <= '0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst && do_load) begin
                    mem[wr_ptr] <= bus.data_in[(i+1)*W-1 -: W];
                end
            end

            assign bus.out[(i+1)*W-1 -: W]   = (state == ST_RUN) ? word : '0;
            assign bus.fill[(i+1)*CW-1 -: CW] = cnt;
            assign run_vec[i]                 = (state == ST_RUN);
            assign done_vec[i]                = (state == ST_DONE);
        end
    endgenerate

    assign bus.busy = |run_vec;
    assign bus.done = &done_vec;

endmodule
`default_nettype wire

// File: tb/tb_noc_word_injector.sv
`default_nettype none
// ============================================================================
//  tb_noc_word_injector
//  Directed scenarios; expected per-cycle state is queued and checked by a monitor.
//  Rev 1.0
// ============================================================================
module tb_noc_word_injector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noc_word_injector_if #(
        .BIT_WIDTH(4), .LOG_N_ADD(3), .CTRL_BIT(1), .LOG_N_CH(4), .LOG_DEPTH(2)
    ) bus ();

    noc_word_injector #(
        .BIT_WIDTH(4), .LOG_N_ADD(3), .CTRL_BIT(1), .LOG_N_CH(4), .LOG_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] o0;
        logic [7:0] o1;
        logic [2:0] f;
        logic       b;
        logic       d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [127:0] rep(input logic [7:0] w);
        return {16{w}};
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] ws, input int k);
        return ws[31-8*k -: 8];
    endfunction

    // Each entry describes the state visible during the current cycle.
    task automatic exp_push(input string n, input logic [7:0] o0, input logic [7:0] o1,
                            input logic [2:0] f, input logic b, input logic d);
        exp_t e;
        e.name = n; e.o0 = o0; e.o1 = o1; e.f = f; e.b = b; e.d = d;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input logic [15:0] mask, input logic [31:0] words,
                            input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            bus.ld      = mask;
            bus.data_in = rep(byte_at(words, k));
            exp_push(tag, 8'h00, 8'h00, 3'(k), 1'b0, 1'b0);
            step();
        end
        bus.ld = '0;
    endtask

    task automatic oneshot_all(input string tag);
        load_seq(16'hFFFF, 32'hFAC123B6, 4, {tag, "_load"});
        bus.start = 1'b1; bus.mode = 1'b0;
        exp_push({tag, "_start"}, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_push({tag, "_run"}, byte_at(32'hFAC123B6, k), byte_at(32'hFAC123B6, k),
                     3'd4, 1'b1, 1'b0);
            step();
        end
        exp_push({tag, "_done"}, 8'h00, 8'h00, 3'd4, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push({tag, "_clear"}, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            if (bus.out[7:0] !== mon_e.o0 || bus.out[15:8] !== mon_e.o1 ||
                bus.fill[2:0] !== mon_e.f || bus.busy !== mon_e.b || bus.done !== mon_e.d) begin
                failures++;
                $display("FAIL %s: got out0=%h out1=%h fill0=%0d busy=%b done=%b, want out0=%h out1=%h fill0=%0d busy=%b done=%b",
                         mon_e.name, bus.out[7:0], bus.out[15:8], bus.fill[2:0], bus.busy, bus.done,
                         mon_e.o0, mon_e.o1, mon_e.f, mon_e.b, mon_e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ld = '0; bus.data_in = '0; bus.start = 1'b0; bus.mode = 1'b0;
        bus.stop = 1'b0; bus.clear = 1'b0; bus.stall = '0;
        step();
        step();
        exp_push("reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        rst = 1'b1;

        // 1: one-shot replay, extra load on a full buffer is dropped
        load_seq(16'hFFFF, 32'hFAC123B6, 4, "s1_load");
        bus.ld = '1; bus.data_in = rep(8'h77);
        exp_push("s1_full", 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        bus.ld = '0; bus.start = 1'b1; bus.mode = 1'b0;
        exp_push("s1_start", 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_push("s1_run", byte_at(32'hFAC123B6, k), byte_at(32'hFAC123B6, k), 3'd4, 1'b1, 1'b0);
            step();
        end
        exp_push("s1_done", 8'h00, 8'h00, 3'd4, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push("s1_clear", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // 2: channel 0 stalled three edges on a valid word; channel 1 runs on
        load_seq(16'hFFFF, 32'hFAC123B6, 4, "s2_load");
        bus.start = 1'b1;
        exp_push("s2_start", 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        exp_push("s2_w0", 8'hFA, 8'hFA, 3'd4, 1'b1, 1'b0);
        step();
        bus.stall = 16'h0001;
        exp_push("s2_hold", 8'hC1, 8'hC1, 3'd4, 1'b1, 1'b0); step();
        exp_push("s2_hold", 8'hC1, 8'h23, 3'd4, 1'b1, 1'b0); step();
        exp_push("s2_hold", 8'hC1, 8'hB6, 3'd4, 1'b1, 1'b0); step();
        bus.stall = '0;
        exp_push("s2_release", 8'hC1, 8'h00, 3'd4, 1'b1, 1'b0); step();
        exp_push("s2_run", 8'h23, 8'h00, 3'd4, 1'b1, 1'b0); step();
        exp_push("s2_run", 8'hB6, 8'h00, 3'd4, 1'b1, 1'b0); step();
        exp_push("s2_done", 8'h00, 8'h00, 3'd4, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push("s2_clear", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // 3: bubble passes a stall, valid word freezes until stop
        load_seq(16'hFFFF, 32'h58907E00, 3, "s3_load");
        bus.stall = 16'h0001; bus.start = 1'b1;
        exp_push("s3_start", 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        exp_push("s3_bubble", 8'h58, 8'h58, 3'd3, 1'b1, 1'b0); step();
        exp_push("s3_frozen", 8'h90, 8'h90, 3'd3, 1'b1, 1'b0); step();
        exp_push("s3_frozen", 8'h90, 8'h7E, 3'd3, 1'b1, 1'b0); step();
        for (int k = 0; k < 4; k++) begin
            exp_push("s3_frozen", 8'h90, 8'h00, 3'd3, 1'b1, 1'b0);
            step();
        end
        bus.stop = 1'b1;
        exp_push("s3_frozen", 8'h90, 8'h00, 3'd3, 1'b1, 1'b0);
        step();
        bus.stop = 1'b0; bus.stall = '0;
        exp_push("s3_stopped", 8'h00, 8'h00, 3'd3, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push("s3_clear", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // 4: loop mode; ld/start/clear during RUN ignored; stop beats clear
        load_seq(16'hFFFF, 32'h4DFA0000, 2, "s4_load");
        bus.start = 1'b1; bus.mode = 1'b1;
        exp_push("s4_start", 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        step();
        bus.start = 1'b0; bus.mode = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.clear   = (k == 5) || (k == 19);
            bus.ld      = (k == 8) ? 16'hFFFF : 16'h0000;
            bus.data_in = rep(8'h11);
            bus.start   = (k == 11);
            bus.stop    = (k == 19);
            exp_push("s4_loop", (k % 2 == 0) ? 8'h4D : 8'hFA, (k % 2 == 0) ? 8'h4D : 8'hFA,
                     3'd2, 1'b1, 1'b0);
            step();
        end
        bus.stop = 1'b0; bus.ld = '0; bus.start = 1'b0;
        exp_push("s4_stopped", 8'h00, 8'h00, 3'd2, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push("s4_clear", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // 5: empty channels finish at once; done waits for the slowest
        bus.start = 1'b1;
        exp_push("s5_empty_start", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        exp_push("s5_empty_done", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push("s5_idle", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        load_seq(16'h0001, 32'hFAC123B6, 4, "s5_load");
        bus.start = 1'b1;
        exp_push("s5_start", 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_push("s5_run", byte_at(32'hFAC123B6, k), 8'h00, 3'd4, 1'b1, 1'b0);
            step();
        end
        exp_push("s5_done", 8'h00, 8'h00, 3'd4, 1'b0, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_push("s5_clear", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // 6: reset in the middle of a looping replay, then a normal run
        load_seq(16'hFFFF, 32'h4DFA0000, 2, "s6_load");
        bus.start = 1'b1; bus.mode = 1'b1;
        exp_push("s6_start", 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        step();
        bus.start = 1'b0; bus.mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_push("s6_loop", (k % 2 == 0) ? 8'h4D : 8'hFA, (k % 2 == 0) ? 8'h4D : 8'hFA,
                     3'd2, 1'b1, 1'b0);
            step();
        end
        rst = 1'b0;
        exp_push("s6_loop", 8'hFA, 8'hFA, 3'd2, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        exp_push("s6_reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        oneshot_all("s6_after");

        for (int k = 0; k < 10 && q.size() != 0; k++) step();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/noc_word_injector.md
Name: noc_word_injector

Overview:
- Parametrised, synthesizable multi-channel traffic source for the tree NoC; successor to the per-input rotate-register stimulus.
- Each of N_CH channels owns a DEPTH-entry word buffer of |V|ADD|DATA| words. The buffer is filled by load strobes, then replayed into the NoC input port.
- Replay is one-shot or looping, honours per-channel NoC stall, and reports completion.
- Sits directly in front of my_noc's `in` bus and consumes its `stall` bus.

Parameters:
- BIT_WIDTH, 4, data field width.
- LOG_N_ADD, 3, address field width (log2 of adder count).
- CTRL_BIT, 1, valid field width; the MSB of the word is the V bit.
- LOG_N_CH, 4, log2 of channel count; N_CH = 2**LOG_N_CH.
- LOG_DEPTH, 2, log2 of per-channel buffer depth; DEPTH = 2**LOG_DEPTH.
- Derived: W = CTRL_BIT+LOG_N_ADD+BIT_WIDTH; CW = LOG_DEPTH+1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- ld  in  N_CH  per-channel load strobe.
- data_in  in  N_CH*W  load word; channel i occupies [(i+1)*W-1 -: W].
- start  in  1  global replay start.
- mode  in  1  0 = one-shot, 1 = loop; sampled only with start.
- stop  in  1  global abort of replay.
- clear  in  1  return all channels from DONE to IDLE and empty the buffers.
- stall  in  N_CH  per-channel backpressure from the NoC.
- out  out  N_CH*W  injected words, same slicing as data_in.
- fill  out  N_CH*CW  per-channel stored word count, 0..DEPTH.
- busy  out  1  OR over channels of (state==RUN).
- done  out  1  AND over channels of (state==DONE).

Behaviour:
- Reset (rst==0 at an edge): every channel goes to IDLE, wr_ptr=rd_ptr=cnt=sent=0, mode_q=0. Outputs: out=0, fill=0, busy=0, done=0. Buffer contents need not be cleared. Reset overrides every other input, including mid-replay.
- Per-channel FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE, load:
  - ld[i] && cnt<DEPTH: buf[wr_ptr]<=data_in slice, wr_ptr++, cnt++.
  - ld[i] while cnt==DEPTH: ignored, nothing overwritten.
  - ld in RUN or DONE: ignored.
- IDLE, start:
  - start: mode_q<=mode, rd_ptr<=0, sent<=0. Channel goes to RUN if cnt>0, otherwise straight to DONE.
  - start has priority over ld in the same cycle; that ld is dropped.
  - start outside IDLE: ignored.
- Output: out slice = buf[rd_ptr] when state==RUN, else 0. It is a combinational read of registered state, so the first word appears in the cycle after the start edge.
- RUN, consume rule. The current word is consumed at an edge if either:
  - V bit==0 (a bubble, advances regardless of stall), or
  - V bit==1 && stall[i]==0.
- On consume: rd_ptr <= (rd_ptr==cnt-1) ? 0 : rd_ptr+1, and sent++.
- RUN, end of replay:
  - One-shot: the consume with sent==cnt-1 moves the channel to DONE.
  - Loop: rd_ptr wraps and sent wraps to 0; the channel stays in RUN.
- Stall: while stall[i]==1 on a valid word, out holds stable and nothing advances, for any number of cycles.
- stop in RUN: channel goes to DONE at that edge. If a consume coincides with stop, the consume still counts.
- clear in DONE: wr_ptr=rd_ptr=cnt=0, channel returns to IDLE. clear in IDLE or RUN is ignored.
- Simultaneous stop and clear: stop takes effect; clear is ignored that cycle.
- Channels are independent after start. done rises only when the slowest channel finishes.
- fill = cnt, unchanged during replay.

Test Plan (default parameters, W=8):
1. Reset, then ld=16'hFFFF on channel 0 with words FA,C1,23,B6 over four cycles, plus one extra ld -> fill[0]=4, extra word dropped. start with mode=0 and stall=0 -> out[7:0] = FA,C1,23,B6 on consecutive cycles, then 00. done=1 on the fifth cycle after start.
2. Same load, stall[0]=1 for 3 cycles while out[7:0]=C1 -> C1 held 3 cycles. Completion is delayed exactly 3 cycles. Other channels are unaffected.
3. Load 58,90,7E (90 has V=1; 58 and 7E have V=0), stall[0]=1 permanently -> 58 advances, 90 freezes and never completes. stop -> DONE next edge, out=0.
4. Loop mode with 2 words 4D,FA and stall=0 -> out alternates 4D,FA for 20 cycles, busy=1. stop -> done=1. clear -> fill=0, IDLE.
5. Channel 3 empty at start -> it is DONE immediately. Channel 0 with 4 words -> done rises only after channel 0 finishes.
6. rst=0 asserted mid-replay in loop mode -> out=0, fill=0, busy=0 at the next edge. A subsequent load and start behave as in scenario 1.
